// File: rtl/mul_share_pkg.sv
// ---------------------------------------------------------------------------
// mul_share_pkg
// Shared definitions for the shared-multiplier controller:
//   - OP_W / PROD_W operand and product widths
//   - state_e        controller FSM states
//   - rr_pick()      round-robin winner search from a pointer
// ---------------------------------------------------------------------------
package mul_share_pkg;

    localparam int OP_W    = 32;
    localparam int PROD_W  = 64;
    localparam int MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [3:0]         ptr,
                                         input int unsigned        n);
        rr_pick_t    pick;
        int unsigned cand;
        pick.found = 1'b0;
        pick.idx   = 4'd0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            cand = ({28'd0, ptr} + k) % n;
            if ((k < n) && !pick.found && valid[cand[3:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[3:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_wallace.sv
// ---------------------------------------------------------------------------
// mul_share_ctrl_wallace
// Purely combinational unsigned 32x32 -> 64 Wallace-tree multiplier.
// Partial products are reduced with layers of 3:2 carry-save compressors
// until two rows remain, then a single carry-propagate add finishes.
// The path is multicycle: the caller holds a_i/b_i stable for the
// settle window before sampling prod_o.
// Ports:
//   a_i    [31:0]  operand A
//   b_i    [31:0]  operand B
//   prod_o [63:0]  a_i * b_i
// ---------------------------------------------------------------------------
module mul_share_ctrl_wallace
    import mul_share_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] prod_o
);

    // Number of rows left after lvl layers of 3:2 compression.
    function automatic int rows_after(input int lvl);
        int n;
        n = OP_W;
        for (int l = 0; l < lvl; l++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    // Layers needed to get down to two rows.
    function automatic int levels_needed();
        int cnt;
        cnt = 0;
        for (int l = 0; l < 16; l++) begin
            cnt = (rows_after(l) > 2) ? (l + 1) : cnt;
        end
        return cnt;
    endfunction

    localparam int NUM_LVL = levels_needed();

    logic [PROD_W-1:0] row_s [OP_W];
    logic [PROD_W-1:0] nxt_s [OP_W];

    // Partial-product generation, carry-save reduction tree and final add.
    always_comb begin
        for (int i = 0; i < OP_W; i++) begin
            row_s[i] = b_i[i] ? (PROD_W'(a_i) << i) : '0;
            nxt_s[i] = '0;
        end
        for (int l = 0; l < NUM_LVL; l++) begin
            for (int i = 0; i < OP_W; i++) begin
                nxt_s[i] = '0;
            end
            // Each group of three rows becomes a sum row and a shifted carry row.
            for (int g = 0; g < rows_after(l) / 3; g++) begin
                nxt_s[5'(2*g)]   = row_s[5'(3*g)] ^ row_s[5'(3*g+1)] ^ row_s[5'(3*g+2)];
                nxt_s[5'(2*g+1)] = ((row_s[5'(3*g)]   & row_s[5'(3*g+1)]) |
                                    (row_s[5'(3*g)]   & row_s[5'(3*g+2)]) |
                                    (row_s[5'(3*g+1)] & row_s[5'(3*g+2)])) << 1;
            end
            // Leftover rows (0..2) pass straight to the next layer.
            for (int i = 3 * (rows_after(l) / 3); i < rows_after(l); i++) begin
                nxt_s[5'(2 * (rows_after(l) / 3) + i - 3 * (rows_after(l) / 3))] = row_s[5'(i)];
            end
            for (int i = 0; i < OP_W; i++) begin
                row_s[i] = nxt_s[i];
            end
        end
        prod_o = row_s[0] + row_s[1];
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// ---------------------------------------------------------------------------
// mul_share_ctrl
// Shares one combinational Wallace multiplier among NUM_REQ requesters.
// Round-robin grant in IDLE, operands held for MUL_CYCLES in CALC, product
// presented with the requester ID in RESP until resp_ready.
// Optional build macro MUL_SHARE_SIGNED_EN adds per-requester signed
// operation (req_signed); without it every multiply is unsigned.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (ready one-hot)
//   req_a/req_b         packed operands, requester i at [32i+31:32i]
//   req_signed          (MUL_SHARE_SIGNED_EN only) signed request flags
//   resp_valid/ready    response handshake
//   resp_id/resp_prod   owner ID and 64-bit product
//   busy                high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int MUL_CYCLES = 2,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
`ifdef MUL_SHARE_SIGNED_EN
    input  logic [NUM_REQ-1:0]      req_signed,
`endif
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [PROD_W-1:0]       resp_prod,
    output logic                    busy
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [PROD_W-1:0]  resp_prod_q, resp_prod_d;
    logic               resp_valid_q, resp_valid_d;
    logic               neg_q, neg_d;

    rr_pick_t           pick_s;
    logic [OP_W-1:0]    win_a_s, win_b_s, lat_a_s, lat_b_s;
    logic               win_sgn_s, neg_s;
    logic [PROD_W-1:0]  mul_prod_s, cap_prod_s;

    assign pick_s = rr_pick(16'(req_valid), 4'(rr_ptr_q), NUM_REQ);

    // Mux the winner's operands (and sign flag) out of the packed buses.
    always_comb begin
        win_a_s   = '0;
        win_b_s   = '0;
        win_sgn_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_a_s = win_a_s | ({OP_W{pick_s.idx == 4'(i)}} & req_a[i*OP_W +: OP_W]);
            win_b_s = win_b_s | ({OP_W{pick_s.idx == 4'(i)}} & req_b[i*OP_W +: OP_W]);
`ifdef MUL_SHARE_SIGNED_EN
            win_sgn_s = win_sgn_s | ((pick_s.idx == 4'(i)) & req_signed[i]);
`else
            win_sgn_s = 1'b0;
`endif
        end
    end

`ifdef MUL_SHARE_SIGNED_EN
    // Signed requests latch magnitudes; the sign is reapplied at capture.
    assign lat_a_s    = (win_sgn_s && win_a_s[OP_W-1]) ? (~win_a_s + 32'd1) : win_a_s;
    assign lat_b_s    = (win_sgn_s && win_b_s[OP_W-1]) ? (~win_b_s + 32'd1) : win_b_s;
    assign neg_s      = win_sgn_s & (win_a_s[OP_W-1] ^ win_b_s[OP_W-1]);
    assign cap_prod_s = neg_q ? (~mul_prod_s + 64'd1) : mul_prod_s;
`else
    assign lat_a_s    = win_a_s;
    assign lat_b_s    = win_b_s;
    assign neg_s      = win_sgn_s;
    assign cap_prod_s = mul_prod_s;
`endif

    mul_share_ctrl_wallace u_wallace (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .prod_o (mul_prod_s)
    );

    // Next-state, datapath load and grant logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        resp_id_d    = resp_id_q;
        resp_prod_d  = resp_prod_q;
        resp_valid_d = resp_valid_q;
        neg_d        = neg_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = pick_s.found && (pick_s.idx == 4'(i));
                end
                // A winner only exists when its valid is high, so the grant
                // and the handshake are the same event.
                if (pick_s.found) begin
                    state_d   = CALC;
                    op_a_d    = lat_a_s;
                    op_b_d    = lat_b_s;
                    neg_d     = neg_s;
                    resp_id_d = ID_W'(pick_s.idx);
                    cnt_d     = CNT_W'(MUL_CYCLES - 1);
                    rr_ptr_d  = (pick_s.idx == 4'(NUM_REQ - 1)) ? '0 : ID_W'(pick_s.idx + 4'd1);
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    resp_prod_d  = cap_prod_s;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            neg_q        <= 1'b0;
            resp_id_q    <= '0;
            resp_prod_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            neg_q        <= neg_d;
            resp_id_q    <= resp_id_d;
            resp_prod_q  <= resp_prod_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_prod  = resp_prod_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_share_ctrl
// Scoreboard bench for mul_share_ctrl (NUM_REQ=4, MUL_CYCLES=2). Accepted
// requests push a hand-computed expected product; a response monitor pops
// and compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_mul_share_ctrl;

    localparam int NUM_REQ    = 4;
    localparam int MUL_CYCLES = 2;
    localparam int ID_W       = 2;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_signed;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [63:0]           resp_prod;
    logic                  busy;

    mul_share_ctrl #(.NUM_REQ(NUM_REQ), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef MUL_SHARE_SIGNED_EN
        .req_signed (req_signed),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_prod  (resp_prod),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          t;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_tab [NUM_REQ];
    int          grant_log[$];
    int          grant_t[$];
    int          n_checks    = 0;
    int          n_errors    = 0;
    int          cyc         = 0;
    int          accept_cnt  = 0;
    int          resp_cnt    = 0;
    bit          prev_valid  = 1'b0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Accept monitor: record grants and push the expected response.
    always @(negedge clk) begin
        if (!rst && ((req_valid & req_ready) != '0)) begin
            check64("ready_onehot", 64'($countones(req_ready)), 64'd1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back('{id: i, prod: exp_tab[i], t: cyc});
                    grant_log.push_back(i);
                    grant_t.push_back(cyc);
                    accept_cnt++;
                end
            end
        end
    end

    // Response monitor: latency on rising valid, contents on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp_valid: got id %0d prod 0x%016h expected no response", resp_id, resp_prod);
            end else begin
                check64("latency", 64'(cyc - exp_q[0].t), 64'(MUL_CYCLES + 1));
            end
        end
        if (!rst && resp_valid && resp_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check64("resp_id", 64'(resp_id), 64'(e.id));
            check64("resp_prod", resp_prod, e.prod);
            resp_cnt++;
        end
        prev_valid = resp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        exp_tab[i]        = p;
    endtask

    task automatic wait_accepts(input int target, input string name);
        int k;
        for (k = 0; k < 100 && accept_cnt < target; k++) tick();
        check64(name, 64'(accept_cnt >= target), 64'd1);
    endtask

    task automatic wait_resps(input int target, input string name);
        int k;
        for (k = 0; k < 100 && resp_cnt < target; k++) tick();
        check64(name, 64'(resp_cnt >= target), 64'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [63:0] vp [4];
    int          vid[4];
    int          rr_exp[5];

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_signed = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) exp_tab[i] = 64'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tick();

        // Reset / idle
        check64("rst_busy",       64'(busy),       64'd0);
        check64("rst_resp_valid", 64'(resp_valid), 64'd0);
        check64("rst_req_ready",  64'(req_ready),  64'd0);
        check64("rst_resp_prod",  resp_prod,       64'd0);
        check64("rst_resp_id",    64'(resp_id),    64'd0);

        // Single request from requester 2
        resp_ready = 1'b1;
        set_req(2, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060);
        req_valid = 4'b0100;
        #1;
        check64("ready_req2", 64'(req_ready), 64'h4);
        wait_accepts(1, "accept_single");
        check64("calc_busy",  64'(busy),      64'd1);
        check64("calc_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        wait_resps(1, "resp_single");

        // Directed operand table, one requester at a time
        va  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        vb  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        vp  = '{64'hFFFF_FFFE_0000_0001, 64'h0, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF};
        vid = '{3, 0, 1, 2};
        for (int v = 0; v < 4; v++) begin
            set_req(vid[v], va[v], vb[v], vp[v]);
            req_valid = 4'(1 << vid[v]);
            wait_accepts(2 + v, "accept_vec");
            req_valid = '0;
            wait_resps(2 + v, "resp_vec");
        end

        // Round robin from rr_ptr=0 with everyone requesting
        pulse_reset();
        tick();
        grant_log.delete();
        grant_t.delete();
        set_req(0, 32'd3,         32'd5,         64'h0000_0000_0000_000F);
        set_req(1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        set_req(2, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060);
        set_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        req_valid = 4'b1111;
        wait_accepts(accept_cnt + 5, "accept_rr");
        req_valid = '0;
        wait_resps(resp_cnt + exp_q.size(), "resp_rr");
        rr_exp = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5; j++) begin
            check64("rr_order", 64'((j < grant_log.size()) ? grant_log[j] : -1), 64'(rr_exp[j]));
        end
        for (int j = 1; j < 5; j++) begin
            check64("rr_spacing", 64'((j < grant_t.size()) ? grant_t[j] - grant_t[j-1] : -1),
                    64'(MUL_CYCLES + 2));
        end

        // Backpressure: hold RESP for 10 cycles while requester 0 waits
        resp_ready = 1'b0;
        set_req(1, 32'd3, 32'd7, 64'h0000_0000_0000_0015);
        req_valid = 4'b0010;
        wait_accepts(accept_cnt + 1, "accept_bp");
        req_valid = 4'b0001;
        for (int k = 0; k < 20 && !resp_valid; k++) tick();
        for (int k = 0; k < 10; k++) begin
            check64("bp_valid", 64'(resp_valid), 64'd1);
            check64("bp_id",    64'(resp_id),    64'd1);
            check64("bp_prod",  resp_prod,       64'h15);
            check64("bp_ready", 64'(req_ready),  64'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check64("hs_no_grant", 64'(req_ready), 64'd0);
        tick();
        check64("post_hs_busy",  64'(busy),       64'd0);
        check64("post_hs_valid", 64'(resp_valid), 64'd0);
        check64("post_hs_ready", 64'(req_ready),  64'h1);
        wait_accepts(accept_cnt + 1, "accept_after_bp");
        req_valid = '0;
        wait_resps(resp_cnt + exp_q.size(), "resp_after_bp");

        // Reset one cycle after accept: in-flight op is abandoned
        set_req(1, 32'd5, 32'd6, 64'd30);
        set_req(3, 32'd7, 32'd7, 64'd49);
        req_valid = 4'b0010;
        wait_accepts(accept_cnt + 1, "accept_abort");
        req_valid = '0;
        pulse_reset();
        check64("abort_busy",  64'(busy),       64'd0);
        check64("abort_valid", 64'(resp_valid), 64'd0);
        grant_log.delete();
        req_valid = 4'b1010;
        wait_accepts(accept_cnt + 1, "accept_rereq");
        req_valid = 4'b1000;
        wait_accepts(accept_cnt + 1, "accept_rereq3");
        req_valid = '0;
        check64("rereq_first",  64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd1);
        check64("rereq_second", 64'((grant_log.size() > 1) ? grant_log[1] : -1), 64'd3);
        wait_resps(resp_cnt + exp_q.size(), "resp_rereq");

`ifdef MUL_SHARE_SIGNED_EN
        // Signed and unsigned interpretation of the same bits
        req_signed = 4'b0100;
        set_req(2, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        req_valid = 4'b0100;
        wait_accepts(accept_cnt + 1, "accept_signed");
        req_valid = '0;
        wait_resps(resp_cnt + 1, "resp_signed");
        req_signed = 4'b0000;
        set_req(2, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA);
        req_valid = 4'b0100;
        wait_accepts(accept_cnt + 1, "accept_unsigned");
        req_valid = '0;
        wait_resps(resp_cnt + 1, "resp_unsigned");
`endif

        repeat (5) tick();
        check64("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
